// File: rtl/multiplier_4_bit_unsigned_arb_v.sv
// Round-robin arbiter sharing one registered 4x4 unsigned multiplier among N_REQ requesters.
// One multiply in flight at a time: IDLE grants, CALC registers the product, HOLD waits for the consumer.

module multiplier_4_bit_unsigned_v (
   input  logic [3:0] i_au,
   input  logic [3:0] i_bu,
   output logic [7:0] o_fu
);
   assign o_fu = {4'b0000, i_au} * {4'b0000, i_bu};
endmodule

module multiplier_4_bit_unsigned_arb_v #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2,
   parameter int CNT_W = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [N_REQ-1:0]     i_req_valid,
   input  logic [4*N_REQ-1:0]   i_req_au,
   input  logic [4*N_REQ-1:0]   i_req_bu,
   output logic [N_REQ-1:0]     o_req_ready,
   output logic                 o_rsp_valid,
   output logic [ID_W-1:0]      o_rsp_id,
   output logic [7:0]           o_rsp_fu,
   input  logic                 i_rsp_ready,
   output logic                 o_busy,
   output logic [CNT_W-1:0]     o_done_cnt
);

   typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [3:0]        au_q, au_d, bu_q, bu_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
   logic [7:0]        rsp_fu_q, rsp_fu_d;
   logic [CNT_W-1:0]  done_cnt_q, done_cnt_d;

   logic              gnt_found;
   logic [ID_W-1:0]   gnt_id;
   logic [N_REQ-1:0]  gnt_oh;
   logic [3:0]        gnt_au, gnt_bu;
   logic [7:0]        mul_fu;

   multiplier_4_bit_unsigned_v u_mul (
      .i_au (au_q),
      .i_bu (bu_q),
      .o_fu (mul_fu)
   );

   // Search upward from ptr, wrapping; the first valid requester wins.
   always_comb begin
      int idx;
      gnt_found = 1'b0;
      gnt_id    = '0;
      gnt_oh    = '0;
      gnt_au    = '0;
      gnt_bu    = '0;
      idx       = 0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = int'(ptr_q) + i;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!gnt_found && i_req_valid[idx]) begin
            gnt_found   = 1'b1;
            gnt_id      = ID_W'(idx);
            gnt_oh[idx] = 1'b1;
            gnt_au      = i_req_au[4*idx +: 4];
            gnt_bu      = i_req_bu[4*idx +: 4];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      au_d        = au_q;
      bu_d        = bu_q;
      id_d        = id_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_fu_d    = rsp_fu_q;
      done_cnt_d  = done_cnt_q;
      case (state_q)
         IDLE: begin
            if (gnt_found) begin
               au_d    = gnt_au;
               bu_d    = gnt_bu;
               id_d    = gnt_id;
               ptr_d   = (int'(gnt_id) == N_REQ-1) ? '0 : gnt_id + ID_W'(1);
               state_d = CALC;
            end
         end
         CALC: begin
            rsp_fu_d    = mul_fu;
            rsp_id_d    = id_q;
            rsp_valid_d = 1'b1;
            state_d     = HOLD;
         end
         HOLD: begin
            if (i_rsp_ready) begin
               rsp_valid_d = 1'b0;
               done_cnt_d  = done_cnt_q + CNT_W'(1);
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         au_q        <= '0;
         bu_q        <= '0;
         id_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_fu_q    <= '0;
         done_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         au_q        <= au_d;
         bu_q        <= bu_d;
         id_q        <= id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_fu_q    <= rsp_fu_d;
         done_cnt_q  <= done_cnt_d;
      end
   end

   assign o_req_ready = (state_q == IDLE) ? gnt_oh : '0;
   assign o_rsp_valid = rsp_valid_q;
   assign o_rsp_id    = rsp_id_q;
   assign o_rsp_fu    = rsp_fu_q;
   assign o_busy      = (state_q != IDLE);
   assign o_done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_multiplier_4_bit_unsigned_arb_v.sv
// Directed bench for the round-robin multiplier arbiter; CNT_W=4 so the counter wrap is reachable.

module tb_multiplier_4_bit_unsigned_arb_v;

   localparam int N_REQ = 4;
   localparam int ID_W  = 2;
   localparam int CNT_W = 4;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [N_REQ-1:0]   req_valid;
   logic [4*N_REQ-1:0] req_au, req_bu;
   logic [N_REQ-1:0]   req_ready;
   logic               rsp_valid;
   logic [ID_W-1:0]    rsp_id;
   logic [7:0]         rsp_fu;
   logic               rsp_ready;
   logic               busy;
   logic [CNT_W-1:0]   done_cnt;

   int                 n_cmp = 0;
   int                 n_err = 0;
   logic [CNT_W-1:0]   exp_cnt;

   multiplier_4_bit_unsigned_arb_v #(.N_REQ(N_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_req_valid (req_valid),
      .i_req_au    (req_au),
      .i_req_bu    (req_bu),
      .o_req_ready (req_ready),
      .o_rsp_valid (rsp_valid),
      .o_rsp_id    (rsp_id),
      .o_rsp_fu    (rsp_fu),
      .i_rsp_ready (rsp_ready),
      .o_busy      (busy),
      .o_done_cnt  (done_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
         $error("%s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int k, input logic [3:0] a, input logic [3:0] b);
      req_au[4*k +: 4] = a;
      req_bu[4*k +: 4] = b;
   endtask

   // Single requester k, full handshake, immediate accept.
   task automatic do_txn(input int k, input logic [3:0] a, input logic [3:0] b, input logic [7:0] prod);
      req_valid = '0;
      req_valid[k] = 1'b1;
      set_req(k, a, b);
      #1;
      chk("txn_ready", 32'(req_ready), 32'(1 << k));
      chk("txn_idle_busy", 32'(busy), 0);
      step();
      req_valid = '0;
      set_req(k, 4'hA, 4'h5);
      chk("txn_calc_busy", 32'(busy), 1);
      chk("txn_calc_ready", 32'(req_ready), 0);
      chk("txn_calc_valid", 32'(rsp_valid), 0);
      step();
      chk("txn_rsp_valid", 32'(rsp_valid), 1);
      chk("txn_rsp_id", 32'(rsp_id), 32'(k));
      chk("txn_rsp_fu", 32'(rsp_fu), 32'(prod));
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      exp_cnt = exp_cnt + 1'b1;
      chk("txn_rsp_dropped", 32'(rsp_valid), 0);
      chk("txn_done_cnt", 32'(done_cnt), 32'(exp_cnt));
      chk("txn_fu_kept", 32'(rsp_fu), 32'(prod));
   endtask

   initial begin
      rst_n = 1'b0; req_valid = '0; req_au = '0; req_bu = '0; rsp_ready = 1'b0;
      exp_cnt = '0;
      #1;
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_id", 32'(rsp_id), 0);
      chk("rst_rsp_fu", 32'(rsp_fu), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done_cnt", 32'(done_cnt), 0);
      chk("rst_ready", 32'(req_ready), 0);
      step(); step();
      rst_n = 1'b1;
      step();

      // requester 2 alone: 7*9
      do_txn(2, 4'd7, 4'd9, 8'd63);

      // reset so the pointer starts at 0, then all four valid back to back
      rst_n = 1'b0; #1; rst_n = 1'b1; exp_cnt = '0;
      step();
      set_req(0, 4'd1, 4'd2); set_req(1, 4'd2, 4'd3);
      set_req(2, 4'd3, 4'd4); set_req(3, 4'd4, 4'd5);
      req_valid = 4'b1111;
      rsp_ready = 1'b1;
      for (int g = 0; g < 5; g++) begin
         int k;
         logic [7:0] prod;
         k = g % 4;
         prod = 8'((k + 1) * (k + 2));
         #1;
         chk("rr_grant", 32'(req_ready), 32'(1 << k));
         chk("rr_idle_busy", 32'(busy), 0);
         step();
         chk("rr_calc_busy", 32'(busy), 1);
         step();
         chk("rr_rsp_valid", 32'(rsp_valid), 1);
         chk("rr_rsp_id", 32'(rsp_id), 32'(k));
         chk("rr_rsp_fu", 32'(rsp_fu), 32'(prod));
         chk("rr_hold_busy", 32'(busy), 1);
         step();
         exp_cnt = exp_cnt + 1'b1;
         chk("rr_done_cnt", 32'(done_cnt), 32'(exp_cnt));
      end
      req_valid = '0;
      rsp_ready = 1'b0;

      // boundary operands
      do_txn(1, 4'd15, 4'd15, 8'd225);
      do_txn(0, 4'd0, 4'd13, 8'd0);

      // back-pressure: requester 0 in flight, requester 3 waiting
      req_valid = 4'b0001;
      set_req(0, 4'd3, 4'd4);
      set_req(3, 4'd5, 4'd6);
      step();
      req_valid = 4'b1000;
      step();
      for (int c = 0; c < 5; c++) begin
         chk("bp_rsp_valid", 32'(rsp_valid), 1);
         chk("bp_rsp_id", 32'(rsp_id), 0);
         chk("bp_rsp_fu", 32'(rsp_fu), 12);
         chk("bp_ready_zero", 32'(req_ready), 0);
         step();
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      exp_cnt = exp_cnt + 1'b1;
      chk("bp_released", 32'(rsp_valid), 0);
      chk("bp_grant3", 32'(req_ready), 32'h8);
      step();
      req_valid = '0;
      step();
      chk("bp_rsp3_id", 32'(rsp_id), 3);
      chk("bp_rsp3_fu", 32'(rsp_fu), 30);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      exp_cnt = exp_cnt + 1'b1;
      chk("bp_done_cnt", 32'(done_cnt), 32'(exp_cnt));

      // reset during CALC discards the transaction
      req_valid = 4'b0010;
      set_req(1, 4'd2, 4'd3);
      step();
      req_valid = '0;
      chk("mid_calc_busy", 32'(busy), 1);
      rst_n = 1'b0;
      #1;
      exp_cnt = '0;
      chk("mid_rst_valid", 32'(rsp_valid), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_cnt", 32'(done_cnt), 0);
      chk("mid_rst_fu", 32'(rsp_fu), 0);
      step();
      rst_n = 1'b1;
      step();
      chk("post_rst_no_rsp", 32'(rsp_valid), 0);
      req_valid = 4'b0011;
      set_req(0, 4'd6, 4'd7);
      set_req(1, 4'd2, 4'd3);
      #1;
      chk("post_rst_grant0", 32'(req_ready), 1);
      req_valid = '0;
      do_txn(0, 4'd6, 4'd7, 8'd42);

      // 16 more accepts -> 17 total since reset, counter wraps to 1
      for (int i = 0; i < 16; i++) begin
         logic [3:0] a, b;
         a = 4'(i);
         b = 4'(15 - i);
         do_txn(i % 4, a, b, 8'(i * (15 - i)));
      end
      chk("wrap_cnt", 32'(done_cnt), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
